// File: rtl/pdm_pkg.sv
// Shared PDM constants and sample type. Used by the modulator, the saw/sine
// generators and the demodulator.
package pdm_pkg;
  localparam int PDM_WIDTH    = 10;
  localparam int PDM_DEC_LOG2 = 10;

  typedef logic [PDM_WIDTH-1:0] pdm_sample_t;
endpackage

// File: rtl/pdm_demod_if.sv
// Demodulator bus: count enable and PDM bit in, decoded sample and strobes out.
interface pdm_demod_if
  import pdm_pkg::*;
#(
  parameter int WIDTH = PDM_WIDTH
);
  logic             en;
  logic             pdm_in;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             overrange;

  modport master (output en, pdm_in, input sample, sample_valid, overrange);
  modport slave  (input en, pdm_in, output sample, sample_valid, overrange);
endinterface

// File: rtl/pdm_sync2.sv
// Two-flop synchroniser with async active-low clear, for pin and button inputs.
module pdm_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/pdm_demod.sv
// Integrate-and-dump PDM decoder: counts ones over 2^DEC_LOG2 enabled clocks.
// Define PDM_DEMOD_SMOOTH_EN to average the last four window results.
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int WIDTH    = PDM_WIDTH,
  parameter int DEC_LOG2 = PDM_DEC_LOG2
) (
  input logic        clk,
  input logic        rst_n,
  pdm_demod_if.slave bus
);
  localparam int SHIFT = DEC_LOG2 - WIDTH;

  generate
    if (DEC_LOG2 < WIDTH) begin : g_bad_params
      $error("pdm_demod: DEC_LOG2 must be >= WIDTH");
    end
  endgenerate

  logic                s2;
  logic [DEC_LOG2-1:0] win_cnt;
  logic [DEC_LOG2:0]   ones_acc;
  logic [DEC_LOG2:0]   total;
  logic [WIDTH:0]      scaled;
  logic                close;
  logic                sat;
  logic [WIDTH-1:0]    sat_val;
  logic [WIDTH-1:0]    next_sample;
  logic [WIDTH-1:0]    sample_q;
  logic                valid_q;
  logic                over_q;

  pdm_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pdm_in),
    .q     (s2)
  );

  // The last bit of a window is folded in combinationally so the dump and the
  // clear of the accumulator happen on the same edge.
  assign close   = bus.en & (&win_cnt);
  assign total   = ones_acc + {{DEC_LOG2{1'b0}}, s2};
  assign scaled  = (WIDTH+1)'(total >> SHIFT);
  assign sat     = scaled[WIDTH];
  assign sat_val = sat ? '1 : scaled[WIDTH-1:0];

`ifdef PDM_DEMOD_SMOOTH_EN
  // Four-tap history: the newest entry is sat_val itself, the three older ones
  // are held here, so the average includes the current window without delay.
  logic [2:0][WIDTH-1:0] hist;
  logic [WIDTH+1:0]      sum;

  always_comb begin
    sum = {2'b00, sat_val} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    next_sample = WIDTH'(sum >> 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (close) begin
      hist <= {hist[1], hist[0], sat_val};
    end
  end
`else
  assign next_sample = sat_val;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      ones_acc <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      over_q  <= 1'b0;
      if (bus.en) begin
        win_cnt  <= win_cnt + DEC_LOG2'(1);
        ones_acc <= close ? '0 : total;
        if (close) begin
          sample_q <= next_sample;
          valid_q  <= 1'b1;
          over_q   <= sat;
        end
      end
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.overrange    = over_q;
endmodule
